exec_stage: RTL and testbench

Execute stage of the 4-stage pipelined 32-bit processor (fetch, decode, execute, write), built on a MIPS-like ISA.
- Holds the decode→execute pipeline register.
- Computes the ALU or address result for the registered instruction.
- Owns the 1 KiB byte-lane data memory.
- Its outputs feed the execute→write register and the PC/branch logic; forwarding muxes sit outside this block.

---
 rtl/isa_pkg.sv | 43 ++++
 rtl/byte_lane_ram.sv | 31 +++
 rtl/exec_stage.sv | 161 ++++++++++++++++
 tb/tb_exec_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// ----------------------------------------------------------------------------
// isa_pkg
// Shared ISA definitions for the 4-stage MIPS-like pipeline: opcode and R-type
// funct encodings plus the link register number used by jal.
// ----------------------------------------------------------------------------
package isa_pkg;

    // Opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd1;
    localparam logic [5:0] OP_LUI   = 6'd3;
    localparam logic [5:0] OP_ANDI  = 6'd4;
    localparam logic [5:0] OP_ORI   = 6'd5;
    localparam logic [5:0] OP_XORI  = 6'd6;
    localparam logic [5:0] OP_LW    = 6'd16;
    localparam logic [5:0] OP_LH    = 6'd18;
    localparam logic [5:0] OP_LB    = 6'd20;
    localparam logic [5:0] OP_SW    = 6'd24;
    localparam logic [5:0] OP_SH    = 6'd26;
    localparam logic [5:0] OP_SB    = 6'd28;
    localparam logic [5:0] OP_BEQ   = 6'd32;
    localparam logic [5:0] OP_BNE   = 6'd33;
    localparam logic [5:0] OP_BLT   = 6'd34;
    localparam logic [5:0] OP_BLE   = 6'd35;
    localparam logic [5:0] OP_J     = 6'd40;
    localparam logic [5:0] OP_JAL   = 6'd41;
    localparam logic [5:0] OP_JR    = 6'd42;

    // R-type funct codes (aux[4:0])
    localparam logic [4:0] FN_ADD = 5'd0;
    localparam logic [4:0] FN_SUB = 5'd2;
    localparam logic [4:0] FN_AND = 5'd8;
    localparam logic [4:0] FN_OR  = 5'd9;
    localparam logic [4:0] FN_XOR = 5'd10;
    localparam logic [4:0] FN_NOR = 5'd11;
    localparam logic [4:0] FN_SLL = 5'd16;
    localparam logic [4:0] FN_SRL = 5'd17;
    localparam logic [4:0] FN_SRA = 5'd18;

    // Link register written by jal
    localparam logic [4:0] RA = 5'd31;

endpackage

// File: rtl/byte_lane_ram.sv
// ----------------------------------------------------------------------------
// byte_lane_ram
// One 8-bit lane of the data memory: DM_WORDS entries, synchronous write,
// asynchronous read. Four of these form the 32-bit byte-addressable memory.
//   clk   : write clock
//   we    : lane write enable
//   addr  : word index (shared by read and write)
//   wdata : byte to write
//   rdata : byte currently stored at addr
// ----------------------------------------------------------------------------
module byte_lane_ram #(
    parameter int DM_WORDS = 256
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [$clog2(DM_WORDS)-1:0] addr,
    input  logic [7:0]                  wdata,
    output logic [7:0]                  rdata
);

    logic [7:0] mem [DM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/exec_stage.sv
// ----------------------------------------------------------------------------
// exec_stage
// Execute stage: decode->execute pipeline register, ALU / address generation,
// load extraction, store lane steering, and the 1 KiB byte-lane data memory.
//   clk, rstd          : clock, synchronous active-high reset (NOP bubble)
//   *_in               : decoded instruction fields and register read data
//   *_out              : registered copies of the *_in fields
//   wreg               : destination register (0 = no write-back)
//   wren               : data-memory byte-lane write enables
//   dm_addr            : word address (effective address >> 2)
//   result             : write-back value, or lane-replicated store data
// ----------------------------------------------------------------------------
module exec_stage
    import isa_pkg::*;
#(
    parameter int DM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic [31:0] pc_in,
    input  logic [5:0]  op_in,
    input  logic [4:0]  rs_in,
    input  logic [4:0]  rt_in,
    input  logic [4:0]  rd_in,
    input  logic [10:0] aux_in,
    input  logic [31:0] imm_dpl_in,
    input  logic [25:0] addr_in,
    input  logic [31:0] os_in,
    input  logic [31:0] ot_in,
    output logic [31:0] pc_out,
    output logic [5:0]  op_out,
    output logic [4:0]  rs_out,
    output logic [4:0]  rt_out,
    output logic [4:0]  rd_out,
    output logic [10:0] aux_out,
    output logic [31:0] imm_dpl_out,
    output logic [25:0] addr_out,
    output logic [31:0] os_out,
    output logic [31:0] ot_out,
    output logic [4:0]  wreg,
    output logic [3:0]  wren,
    output logic [31:0] dm_addr,
    output logic [31:0] result
);

    localparam int AW = $clog2(DM_WORDS);

    logic [31:0]   ea;
    logic [AW-1:0] dm_idx;
    logic [4:0]    shamt;
    logic [4:0]    funct;
    logic [7:0]    rd_lane [4];
    logic [31:0]   rd_word;
    logic [15:0]   rd_half;
    logic [7:0]    rd_byte;

    // Pipeline register; reset inserts an all-zero NOP bubble.
    always_ff @(posedge clk) begin
        if (rstd) begin
            pc_out      <= '0;
            op_out      <= '0;
            rs_out      <= '0;
            rt_out      <= '0;
            rd_out      <= '0;
            aux_out     <= '0;
            imm_dpl_out <= '0;
            addr_out    <= '0;
            os_out      <= '0;
            ot_out      <= '0;
        end else begin
            pc_out      <= pc_in;
            op_out      <= op_in;
            rs_out      <= rs_in;
            rt_out      <= rt_in;
            rd_out      <= rd_in;
            aux_out     <= aux_in;
            imm_dpl_out <= imm_dpl_in;
            addr_out    <= addr_in;
            os_out      <= os_in;
            ot_out      <= ot_in;
        end
    end

    assign ea      = os_out + imm_dpl_out;
    assign dm_addr = {2'b00, ea[31:2]};
    assign dm_idx  = ea[AW+1:2];
    assign shamt   = aux_out[10:6];
    assign funct   = aux_out[4:0];

    // Memory writes are not gated by reset: a store already in the register
    // when reset arrives still commits on that edge.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        byte_lane_ram #(.DM_WORDS(DM_WORDS)) u_lane (
            .clk   (clk),
            .we    (wren[i]),
            .addr  (dm_idx),
            .wdata (result[8*i +: 8]),
            .rdata (rd_lane[i])
        );
    end

    assign rd_word = {rd_lane[3], rd_lane[2], rd_lane[1], rd_lane[0]};
    assign rd_half = ea[1] ? rd_word[31:16] : rd_word[15:0];
    assign rd_byte = rd_lane[ea[1:0]];

    always_comb begin
        result = '0;
        wreg   = '0;
        wren   = '0;
        unique case (op_out)
            OP_RTYPE: begin
                wreg = rd_out;
                case (funct)
                    FN_ADD: result = os_out + ot_out;
                    FN_SUB: result = os_out - ot_out;
                    FN_AND: result = os_out & ot_out;
                    FN_OR:  result = os_out | ot_out;
                    FN_XOR: result = os_out ^ ot_out;
                    FN_NOR: result = ~(os_out | ot_out);
                    FN_SLL: result = ot_out << shamt;
                    FN_SRL: result = ot_out >> shamt;
                    FN_SRA: result = $unsigned($signed(ot_out) >>> shamt);
                    default: begin
                        result = '0;
                        wreg   = '0;
                    end
                endcase
            end
            OP_ADDI: begin wreg = rt_out; result = ea; end
            OP_LUI:  begin wreg = rt_out; result = imm_dpl_out << 16; end
            OP_ANDI: begin wreg = rt_out; result = os_out & imm_dpl_out; end
            OP_ORI:  begin wreg = rt_out; result = os_out | imm_dpl_out; end
            OP_XORI: begin wreg = rt_out; result = os_out ^ imm_dpl_out; end
            OP_LW:   begin wreg = rt_out; result = rd_word; end
            OP_LH:   begin wreg = rt_out; result = {{16{rd_half[15]}}, rd_half}; end
            OP_LB:   begin wreg = rt_out; result = {{24{rd_byte[7]}}, rd_byte}; end
            OP_SW: begin
                wren   = 4'b1111;
                result = ot_out;
            end
            OP_SH: begin
                wren   = ea[1] ? 4'b1100 : 4'b0011;
                result = {2{ot_out[15:0]}};
            end
            OP_SB: begin
                wren   = 4'b0001 << ea[1:0];
                result = {4{ot_out[7:0]}};
            end
            OP_JAL: begin
                wreg   = RA;
                result = pc_out + 32'd1;
            end
            default: begin
                result = '0;
                wreg   = '0;
                wren   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_exec_stage.sv
// ----------------------------------------------------------------------------
// tb_exec_stage
// Self-checking bench for exec_stage: directed cases followed by randomized
// instructions, compared against a word-array reference memory and an
// instruction-level model of the execute stage.
// ----------------------------------------------------------------------------
module tb_exec_stage;

    typedef struct {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [10:0] aux;
        logic [31:0] imm;
        logic [25:0] addr;
        logic [31:0] os;
        logic [31:0] ot;
    } instr_t;

    logic        clk = 1'b0;
    logic        rstd;
    logic [31:0] pc_in, imm_dpl_in, os_in, ot_in;
    logic [5:0]  op_in;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic [10:0] aux_in;
    logic [25:0] addr_in;
    logic [31:0] pc_out, imm_dpl_out, os_out, ot_out, dm_addr, result;
    logic [5:0]  op_out;
    logic [4:0]  rs_out, rt_out, rd_out, wreg;
    logic [10:0] aux_out;
    logic [25:0] addr_out;
    logic [3:0]  wren;

    int checkCount = 0;
    int failCount  = 0;

    logic [31:0] modelMem [256];
    instr_t      ins;
    instr_t      nop;

    exec_stage #(.DM_WORDS(256)) dut (
        .clk(clk), .rstd(rstd),
        .pc_in(pc_in), .op_in(op_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .aux_in(aux_in), .imm_dpl_in(imm_dpl_in), .addr_in(addr_in),
        .os_in(os_in), .ot_in(ot_in),
        .pc_out(pc_out), .op_out(op_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .aux_out(aux_out), .imm_dpl_out(imm_dpl_out), .addr_out(addr_out),
        .os_out(os_out), .ot_out(ot_out),
        .wreg(wreg), .wren(wren), .dm_addr(dm_addr), .result(result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Instruction-level reference: what the stage should present for one
    // registered instruction, given the reference memory contents.
    function automatic void modelExec(input instr_t i, output logic [31:0] res,
                                      output logic [4:0] wr, output logic [3:0] we);
        logic [31:0] ea;
        logic [31:0] word;
        logic [4:0]  sh;
        ea   = i.os + i.imm;
        word = modelMem[ea[9:2]];
        sh   = i.aux[10:6];
        res  = 32'd0;
        wr   = 5'd0;
        we   = 4'd0;
        case (i.op)
            6'd0: begin
                wr = i.rd;
                case (i.aux[4:0])
                    5'd0:  res = i.os + i.ot;
                    5'd2:  res = i.os - i.ot;
                    5'd8:  res = i.os & i.ot;
                    5'd9:  res = i.os | i.ot;
                    5'd10: res = i.os ^ i.ot;
                    5'd11: res = ~(i.os | i.ot);
                    5'd16: res = i.ot << sh;
                    5'd17: res = i.ot >> sh;
                    5'd18: res = $unsigned($signed(i.ot) >>> sh);
                    default: wr = 5'd0;
                endcase
            end
            6'd1:  begin wr = i.rt; res = i.os + i.imm; end
            6'd3:  begin wr = i.rt; res = {i.imm[15:0], 16'h0000}; end
            6'd4:  begin wr = i.rt; res = i.os & i.imm; end
            6'd5:  begin wr = i.rt; res = i.os | i.imm; end
            6'd6:  begin wr = i.rt; res = i.os ^ i.imm; end
            6'd16: begin wr = i.rt; res = word; end
            6'd18: begin wr = i.rt; res = $unsigned(32'($signed(16'(word >> (16 * ea[1]))))); end
            6'd20: begin wr = i.rt; res = $unsigned(32'($signed(8'(word >> (8 * ea[1:0]))))); end
            6'd24: begin we = 4'b1111; res = i.ot; end
            6'd26: begin we = ea[1] ? 4'b1100 : 4'b0011; res = {i.ot[15:0], i.ot[15:0]}; end
            6'd28: begin we = 4'(1 << ea[1:0]); res = {4{i.ot[7:0]}}; end
            6'd41: begin wr = 5'd31; res = i.pc + 32'd1; end
            default: ;
        endcase
    endfunction

    // Reflect a store into the reference memory (it commits at the next edge).
    function automatic void modelCommit(input instr_t i);
        logic [31:0] ea;
        ea = i.os + i.imm;
        case (i.op)
            6'd24: modelMem[ea[9:2]] = i.ot;
            6'd26: modelMem[ea[9:2]][16 * ea[1] +: 16] = i.ot[15:0];
            6'd28: modelMem[ea[9:2]][8 * ea[1:0] +: 8] = i.ot[7:0];
            default: ;
        endcase
    endfunction

    task automatic applyStimulus(input instr_t i, input logic doReset);
        logic [31:0] expRes;
        logic [4:0]  expWreg;
        logic [3:0]  expWren;
        instr_t      r;
        rstd       = doReset;
        pc_in      = i.pc;   op_in   = i.op;   rs_in  = i.rs;  rt_in = i.rt;
        rd_in      = i.rd;   aux_in  = i.aux;  imm_dpl_in = i.imm;
        addr_in    = i.addr; os_in   = i.os;   ot_in  = i.ot;
        @(posedge clk);
        #1;
        r = doReset ? nop : i;
        modelExec(r, expRes, expWreg, expWren);
        checkOutput("result",  result,          expRes);
        checkOutput("wreg",    32'(wreg),       32'(expWreg));
        checkOutput("wren",    32'(wren),       32'(expWren));
        checkOutput("dm_addr", dm_addr,         (r.os + r.imm) >> 2);
        checkOutput("pc_out",  pc_out,          r.pc);
        checkOutput("op_out",  32'(op_out),     32'(r.op));
        checkOutput("rs_out",  32'(rs_out),     32'(r.rs));
        checkOutput("rt_out",  32'(rt_out),     32'(r.rt));
        checkOutput("rd_out",  32'(rd_out),     32'(r.rd));
        checkOutput("aux_out", 32'(aux_out),    32'(r.aux));
        checkOutput("imm_out", imm_dpl_out,     r.imm);
        checkOutput("addr_out",32'(addr_out),   32'(r.addr));
        checkOutput("os_out",  os_out,          r.os);
        checkOutput("ot_out",  ot_out,          r.ot);
        modelCommit(r);
    endtask

    function automatic instr_t mk(input logic [5:0] op, input logic [31:0] os,
                                  input logic [31:0] imm, input logic [31:0] ot);
        instr_t t;
        t.pc = $urandom; t.op = op; t.rs = 5'($urandom); t.rt = 5'($urandom);
        t.rd = 5'($urandom); t.aux = 11'($urandom); t.imm = imm;
        t.addr = 26'($urandom); t.os = os; t.ot = ot;
        return t;
    endfunction

    function automatic instr_t mkR(input logic [4:0] fn, input logic [4:0] sh,
                                   input logic [31:0] os, input logic [31:0] ot);
        instr_t t;
        t = mk(6'd0, os, $urandom, ot);
        t.rd  = 5'd9;
        t.aux = {sh, 1'b0, fn};
        return t;
    endfunction

    localparam int NUM_OPS = 19;
    logic [5:0] opList [NUM_OPS] = '{6'd0, 6'd1, 6'd3, 6'd4, 6'd5, 6'd6, 6'd16, 6'd18,
                                     6'd20, 6'd24, 6'd26, 6'd28, 6'd32, 6'd33, 6'd34,
                                     6'd35, 6'd40, 6'd41, 6'd42};
    logic [4:0] fnList [9] = '{5'd0, 5'd2, 5'd8, 5'd9, 5'd10, 5'd11, 5'd16, 5'd17, 5'd18};

    initial begin
        nop = '{default: '0};
        for (int w = 0; w < 256; w++) modelMem[w] = 32'd0;

        // Reset bubble, then the first real instruction
        applyStimulus(nop, 1'b1);
        applyStimulus(mk(6'd1, 32'd5, 32'd7, 32'd0), 1'b1);
        ins = mk(6'd1, 32'd5, 32'd7, 32'd0);
        ins.rt = 5'd3;
        applyStimulus(ins, 1'b0);

        // Give every memory word a known random value
        for (int w = 0; w < 256; w++) applyStimulus(mk(6'd24, w * 4, 32'd0, $urandom), 1'b0);

        // R-type directed cases
        applyStimulus(mkR(5'd0,  5'd0, 32'hF0F0F0F0, 32'h0F0F0F0F), 1'b0);
        applyStimulus(mkR(5'd11, 5'd0, 32'hF0F0F0F0, 32'h0F0F0F0F), 1'b0);
        applyStimulus(mkR(5'd2,  5'd0, 32'd1,        32'd2),        1'b0);
        applyStimulus(mkR(5'd18, 5'd4, 32'd0,        32'h80000000), 1'b0);
        applyStimulus(mkR(5'd5,  5'd3, 32'h1234,     32'h5678),     1'b0);

        // Word, byte and half store followed by load
        applyStimulus(mk(6'd24, 32'd0,  32'd8, 32'hDEADBEEF), 1'b0);
        applyStimulus(mk(6'd16, 32'd8,  32'd0, 32'd0),        1'b0);
        applyStimulus(mk(6'd28, 32'd9,  32'd0, 32'h00000080), 1'b0);
        applyStimulus(mk(6'd20, 32'd9,  32'd0, 32'd0),        1'b0);
        applyStimulus(mk(6'd26, 32'd10, 32'd0, 32'h00001234), 1'b0);
        applyStimulus(mk(6'd18, 32'd10, 32'd0, 32'd0),        1'b0);
        applyStimulus(mk(6'd24, 32'd3,  32'd16, 32'h0BADF00D), 1'b0);
        applyStimulus(mk(6'd16, 32'd23, 32'd0, 32'd0),        1'b0);

        // Control flow
        ins = mk(6'd41, $urandom, $urandom, $urandom);
        ins.pc = 32'h40;
        applyStimulus(ins, 1'b0);
        applyStimulus(mk(6'd32, $urandom, $urandom, $urandom), 1'b0);

        // Store in flight when reset arrives still commits
        applyStimulus(mk(6'd28, 32'd100, 32'd1, 32'h000000A5), 1'b0);
        applyStimulus(mk(6'd28, 32'd100, 32'd1, 32'h00000011), 1'b1);
        applyStimulus(mk(6'd20, 32'd101, 32'd0, 32'd0), 1'b0);

        // Randomized instruction stream
        for (int n = 0; n < 600; n++) begin
            ins = mk(opList[$urandom_range(0, NUM_OPS - 1)], $urandom, $urandom, $urandom);
            if ($urandom_range(0, 9) == 0) ins.op = 6'($urandom);
            if ($urandom_range(0, 3) != 0) ins.aux[4:0] = fnList[$urandom_range(0, 8)];
            if ($urandom_range(0, 1) == 0) begin
                ins.os  = $urandom_range(0, 1023);
                ins.imm = $urandom_range(0, 15) - 8;
            end
            applyStimulus(ins, ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
